// File: rtl/record_field_store.sv
// Record store of DEPTH records, each holding field A and a nested field B.
// After reset it initialises every record, then accepts field-selective writes.
module record_field_store #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int INIT_A = 1111,
  parameter int INIT_B = 2222,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH):0]   wr_idx,
  input  logic [1:0]               wr_sel,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     src_load,
  input  logic                     wr_from_src,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         o1,
  output logic [WIDTH-1:0]         o2,
  output logic                     wr_err,
  output logic [CNT_W-1:0]         wr_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef struct packed {
    logic [WIDTH-1:0] b;
  } inner_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    inner_t           nest;
  } record_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  init_ptr_r;
  logic [WIDTH-1:0]  src_r;
  record_t           mem_r [DEPTH];

  logic              wr_acc_s;
  logic              wr_in_range_s;
  logic              rd_hit_s;
  logic [IDX_W-1:0]  wr_slot_s;
  logic [WIDTH-1:0]  wr_val_s;

  assign wr_ready      = (state_r == ST_READY);
  assign wr_acc_s      = wr_valid & wr_ready;
  assign wr_in_range_s = (wr_idx < DEPTH_L);
  assign rd_hit_s      = ({1'b0, rd_idx} < DEPTH_L);
  assign wr_slot_s     = wr_idx[IDX_W-1:0];
  // The source register is read before this cycle's src_load takes effect.
  assign wr_val_s      = wr_from_src ? src_r : wr_data;

  // Sequencer, storage, source register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RESET;
      init_ptr_r <= '0;
      src_r      <= '0;
      o1         <= '0;
      o2         <= '0;
      wr_err     <= 1'b0;
      wr_count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (src_load) begin
        src_r <= wr_data;
      end
      // Reads sample storage before this cycle's write lands.
      if (rd_hit_s) begin
        o1 <= mem_r[rd_idx].a;
        o2 <= mem_r[rd_idx].nest.b;
      end else begin
        o1 <= '0;
        o2 <= '0;
      end
      wr_err <= wr_acc_s & ~wr_in_range_s;

      case (state_r)
        ST_RESET: begin
          state_r    <= ST_INIT;
          init_ptr_r <= '0;
        end
        ST_INIT: begin
          mem_r[init_ptr_r].a      <= WIDTH'(INIT_A);
          mem_r[init_ptr_r].nest.b <= WIDTH'(INIT_B);
          if (init_ptr_r == LAST_IDX) begin
            state_r <= ST_READY;
          end else begin
            init_ptr_r <= init_ptr_r + IDX_W'(1);
          end
        end
        ST_READY: begin
          if (wr_acc_s && wr_in_range_s) begin
            if (wr_sel[0]) begin
              mem_r[wr_slot_s].a <= wr_val_s;
            end
            if (wr_sel[1]) begin
              mem_r[wr_slot_s].nest.b <= wr_val_s;
            end
            if (wr_count != CNT_MAX) begin
              wr_count <= wr_count + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_record_field_store.sv
// Directed self-checking bench for record_field_store (DEPTH=4, CNT_W=2).
module tb_record_field_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_idx;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        src_load;
  logic        wr_from_src;
  logic [1:0]  rd_idx;
  logic [31:0] o1;
  logic [31:0] o2;
  logic        wr_err;
  logic [1:0]  wr_count;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  record_field_store #(
    .WIDTH(32), .DEPTH(4), .INIT_A(1111), .INIT_B(2222), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_sel(wr_sel), .wr_data(wr_data),
    .src_load(src_load), .wr_from_src(wr_from_src), .rd_idx(rd_idx),
    .o1(o1), .o2(o2), .wr_err(wr_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with wr_ready low after reset release, bounded.
  task automatic count_init(output int c);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_ready) break;
      c++;
    end
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_idx = 3'd0; wr_sel = 2'b00; wr_data = 32'd0;
    src_load = 1'b0; wr_from_src = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    rd_idx = 2'd3;
    repeat (3) tick();
    check("rst_o1", o1, 32'd0);
    check("rst_o2", o2, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_err", {31'd0, wr_err}, 32'd0);
    check("rst_count", {30'd0, wr_count}, 32'd0);

    // Release: 4 INIT samples with wr_ready low, rec3 not yet initialised.
    rst_n = 1'b1;
    count_init(cnt);
    check("init_len", cnt, 32'd4);
    check("init_ready", {31'd0, wr_ready}, 32'd1);
    check("init_pending_rd", o1, 32'd0);
    rd_idx = 2'd2;
    tick();
    check("init_a", o1, 32'd1111);
    check("init_b", o2, 32'd2222);

    // Write A of record 1.
    wr_valid = 1'b1; wr_idx = 3'd1; wr_sel = 2'b01; wr_data = 32'd3333; rd_idx = 2'd1;
    tick();
    idle_inputs();
    tick();
    check("wa_o1", o1, 32'd3333);
    check("wa_o2", o2, 32'd2222);
    check("wa_count", {30'd0, wr_count}, 32'd1);

    // Load source, then write B of record 1 from it.
    src_load = 1'b1; wr_data = 32'd9999;
    tick();
    idle_inputs();
    wr_valid = 1'b1; wr_idx = 3'd1; wr_sel = 2'b10; wr_from_src = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("src_o1", o1, 32'd3333);
    check("src_o2", o2, 32'd9999);
    check("src_count", {30'd0, wr_count}, 32'd2);

    // Out-of-range write.
    rd_idx = 2'd0;
    wr_valid = 1'b1; wr_idx = 3'd4; wr_sel = 2'b11; wr_data = 32'd1234;
    tick();
    check("oor_err_pulse", {31'd0, wr_err}, 32'd1);
    idle_inputs();
    tick();
    check("oor_err_clear", {31'd0, wr_err}, 32'd0);
    check("oor_count", {30'd0, wr_count}, 32'd2);
    check("oor_rec0_a", o1, 32'd1111);
    check("oor_rec0_b", o2, 32'd2222);

    // Same-cycle src_load and src write: old source (9999) is written.
    wr_valid = 1'b1; wr_idx = 3'd3; wr_sel = 2'b10; wr_from_src = 1'b1;
    src_load = 1'b1; wr_data = 32'd7777;
    tick();
    idle_inputs();
    rd_idx = 2'd3;
    tick();
    check("same_src_o2", o2, 32'd9999);
    check("same_src_o1", o1, 32'd1111);
    check("same_src_count", {30'd0, wr_count}, 32'd3);

    // Read-before-write on record 0.
    rd_idx = 2'd0;
    wr_valid = 1'b1; wr_idx = 3'd0; wr_sel = 2'b01; wr_data = 32'd5;
    tick();
    check("rbw_old", o1, 32'd1111);
    idle_inputs();
    tick();
    check("rbw_new", o1, 32'd5);
    check("sat_count4", {30'd0, wr_count}, 32'd3);

    // Fifth write uses the source loaded earlier (7777).
    wr_valid = 1'b1; wr_idx = 3'd2; wr_sel = 2'b01; wr_from_src = 1'b1;
    tick();
    idle_inputs();
    rd_idx = 2'd2;
    tick();
    check("src_new_o1", o1, 32'd7777);
    check("sat_count5", {30'd0, wr_count}, 32'd3);

    // Reset, release, abort INIT in its second cycle with an ignored write pending.
    rst_n = 1'b0;
    tick();
    check("rst2_o1", o1, 32'd0);
    check("rst2_count", {30'd0, wr_count}, 32'd0);
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_idx = 3'd1; wr_sel = 2'b11; wr_data = 32'd4444;
    tick();
    tick();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    check("abort_ready", {31'd0, wr_ready}, 32'd0);
    rst_n = 1'b1;
    rd_idx = 2'd1;
    count_init(cnt);
    check("reinit_len", cnt, 32'd4);
    tick();
    check("reinit_a", o1, 32'd1111);
    check("reinit_b", o2, 32'd2222);
    check("reinit_count", {30'd0, wr_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/record_field_store.md
RECORD_FIELD_STORE -- requirements
Module: record_field_store

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each record field.
REQ-002 Parameter DEPTH, default 4: number of records; legal range 2..256.
REQ-003 Parameter INIT_A, default 1111: post-init value of field A (inner scalar) in every record.
REQ-004 Parameter INIT_B, default 2222: post-init value of field B (nested-struct scalar) in every record.
REQ-005 Parameter CNT_W, default 8: width of the write counter.
REQ-006 The module SHALL have one clock, clk, and a synchronous active-low reset, rst_n; no other clock or reset.
REQ-007 Port clk  input  1  clock; all state updates on the rising edge.
REQ-008 Port rst_n  input  1  synchronous active-low reset.
REQ-009 Port wr_valid  input  1  write request.
REQ-010 Port wr_ready  output  1  store accepts writes.
REQ-011 Port wr_idx  input  $clog2(DEPTH)+1  target record index.
REQ-012 Port wr_sel  input  2  field select: bit0 = A, bit1 = B.
REQ-013 Port wr_data  input  WIDTH  write data.
REQ-014 Port src_load  input  1  load the source register from wr_data; no handshake.
REQ-015 Port wr_from_src  input  1  when set, the write data is the source register, not wr_data.
REQ-016 Port rd_idx  input  $clog2(DEPTH)  read index.
REQ-017 Port o1  output  WIDTH  field A of record rd_idx, registered.
REQ-018 Port o2  output  WIDTH  field B of record rd_idx, registered.
REQ-019 Port wr_err  output  1  one-cycle pulse on an accepted write with an out-of-range index.
REQ-020 Port wr_count  output  CNT_W  number of successful writes.

Function
REQ-021 The FSM SHALL have three states: RESET, INIT and READY.
REQ-022 The FSM SHALL go RESET->INIT on the first cycle with rst_n=1.
REQ-023 In INIT, one record per cycle SHALL be written (A=INIT_A, B=INIT_B), indices 0..DEPTH-1 ascending, using an init pointer.
REQ-024 The FSM SHALL go INIT->READY in the cycle after record DEPTH-1 is written; INIT therefore lasts exactly DEPTH cycles.
REQ-025 wr_ready SHALL be 1 only in READY; it is combinational from the state.
REQ-026 A write is accepted when wr_valid & wr_ready; accepted writes are visible on reads from the next cycle.
REQ-027 An accepted write SHALL update only the selected fields; wr_sel=00 changes no field but still counts.
REQ-028 Write data is the source register when wr_from_src=1, otherwise wr_data.
REQ-029 src_load SHALL update the source register in any state, including in the same cycle as a write. A write that uses the source register in that cycle sees the old source value.
REQ-030 The source register SHALL reset to 0.
REQ-031 Reads have 1-cycle latency: o1/o2 in cycle n+1 reflect record rd_idx at the end of cycle n, before that cycle's write (read-before-write).
REQ-032 During INIT, o1/o2 SHALL read the current storage contents; records not yet initialised read 0.
REQ-033 An accepted write with wr_idx >= DEPTH SHALL modify no record, SHALL not increment wr_count, and SHALL pulse wr_err high for the next cycle only.
REQ-034 wr_count SHALL increment by 1 per accepted in-range write and saturate at 2^CNT_W-1; it never wraps.
REQ-035 wr_valid outside READY SHALL be ignored, with no side effects.

Reset
REQ-036 While rst_n=0, on each clock edge: FSM=RESET, all records=0, o1=0, o2=0, wr_err=0, wr_count=0, init pointer=0, wr_ready=0.
REQ-037 A reset asserted mid-INIT or mid-write SHALL abort the operation; the next release restarts INIT from record 0.

Verification
REQ-038 Reset release, DEPTH=4 -> wr_ready=0 for 4 cycles then 1; rd_idx=2 afterwards -> o1=1111, o2=2222.
REQ-039 Write idx1, sel=01, data=3333 -> o1=3333, o2=2222 on the next read of idx1; wr_count=1.
REQ-040 src_load data=9999, then write idx1, sel=10, wr_from_src=1 -> o2=9999, o1 unchanged at 3333.
REQ-041 Write idx=4 (DEPTH=4) -> wr_err pulses once, no record changes, wr_count unchanged.
REQ-042 rd_idx=0 with a same-cycle write idx0 A=5 -> o1=1111 next cycle, then 5 one cycle later.
REQ-043 CNT_W=2, five valid writes -> wr_count=3; reset asserted in INIT cycle 2 -> full 4-cycle INIT after release.
